cmp_sequencer: RTL and testbench

CMP_SEQUENCER -- requirements
Module: cmp_sequencer

---
 rtl/cmp_sequencer_pkg.sv | 42 ++++
 rtl/cmp_sequencer_seg7.sv | 30 +++
 rtl/cmp_sequencer.sv | 149 ++++++++++++++
 tb/tb_cmp_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sequencer_pkg.sv
// Shared types and constants for the compare sequencer: FSM states, compare
// modes, blank segment pattern and the flag computation used in EVAL.
package cmp_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [1:0] MODE_UNSIGNED = 2'b00;
    localparam logic [1:0] MODE_SIGNED   = 2'b01;
    localparam logic [1:0] MODE_EQUAL    = 2'b10;
    localparam logic [1:0] MODE_MAX      = 2'b11;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Returns {gt, eq, lt}; equality-only mode suppresses the ordering flags.
    function automatic logic [2:0] compare_flags(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic [1:0] mode);
        logic signed [3:0] sa;
        logic signed [3:0] sb;
        logic              lt;
        logic              gt;
        sa = a;
        sb = b;
        if (mode == MODE_SIGNED) begin
            lt = (sa < sb);
            gt = (sa > sb);
        end else begin
            lt = (a < b);
            gt = (a > b);
        end
        if (mode == MODE_EQUAL) begin
            lt = 1'b0;
            gt = 1'b0;
        end
        return {gt, (a == b), lt};
    endfunction

endpackage

// File: rtl/cmp_sequencer_seg7.sv
// Hex digit to active-low seven-segment pattern; bit 7 is the decimal point (off).
module seg7_decode (
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        case (digit)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/cmp_sequencer.sv
// Button-stepped 4-bit comparator: debounced KEY[1] captures SW operands, a
// one-cycle EVAL computes flags, SHOW displays them until a step or timeout.
module cmp_sequencer
    import cmp_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 250000000
) (
    input  logic       MAX10_CLK1_50,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic clk;
    logic rst_n;
    assign clk   = MAX10_CLK1_50;
    assign rst_n = KEY[0];

    // Stage p0/p1: two-flop synchronizer, reset to the released level
    logic sync_p0;
    logic sync_p1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= KEY[1];
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: debounced level; a step fires only on an accepted press edge
    logic            pressed;
    logic            step;
    logic [DB_W-1:0] db_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed <= 1'b0;
            step    <= 1'b0;
            db_cnt  <= '0;
        end else begin
            step <= 1'b0;
            if ((!sync_p1) != pressed) begin
                if (db_cnt == DB_LAST) begin
                    pressed <= !sync_p1;
                    step    <= !sync_p1;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    state_t              state;
    state_t              state_next;
    logic [3:0]          a;
    logic [3:0]          b;
    logic [1:0]          mode;
    logic [2:0]          flags;
    logic [3:0]          ones;
    logic [3:0]          tens;
    logic [HOLD_W-1:0]   hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (step) state_next = EVAL;
            EVAL:    state_next = SHOW;
            SHOW:    if (step || (hold_cnt == HOLD_LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            mode     <= '0;
            flags    <= '0;
            ones     <= '0;
            tens     <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (step) begin
                        a    <= SW[3:0];
                        b    <= SW[7:4];
                        mode <= SW[9:8];
                    end
                end
                EVAL: begin
                    flags    <= compare_flags(a, b, mode);
                    hold_cnt <= '0;
                    if (ones == 4'd9) begin
                        ones <= 4'd0;
                        tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
                    end else begin
                        ones <= ones + 4'd1;
                    end
                end
                SHOW:    hold_cnt <= hold_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    logic [3:0] digit_a;
    logic [3:0] digit_b;
    logic [3:0] max_ab;
    logic [7:0] seg_mode;
    logic [7:0] seg_max;

    assign digit_a = (state == IDLE) ? SW[3:0] : a;
    assign digit_b = (state == IDLE) ? SW[7:4] : b;
    assign max_ab  = (a >= b) ? a : b;

    seg7_decode u_hex0 (.digit(digit_a),        .seg(HEX0));
    seg7_decode u_hex1 (.digit(digit_b),        .seg(HEX1));
    seg7_decode u_hex2 (.digit({2'b00, mode}),  .seg(seg_mode));
    seg7_decode u_hex3 (.digit(max_ab),         .seg(seg_max));
    seg7_decode u_hex4 (.digit(ones),           .seg(HEX4));
    seg7_decode u_hex5 (.digit(tens),           .seg(HEX5));

    assign HEX2 = (state == SHOW) ? seg_mode : SEG_BLANK;
    assign HEX3 = ((state == SHOW) && (mode == MODE_MAX)) ? seg_max : SEG_BLANK;
    assign LEDR = {(state != IDLE), 6'b000000, (state == SHOW) ? flags : 3'b000};

endmodule

// File: tb/tb_cmp_sequencer.sv
// Self-checking bench for cmp_sequencer: directed vector table, debounce and
// timing corner cases, and randomized evaluations against an arithmetic model.
module tb_cmp_sequencer;

    localparam int DB   = 4;
    localparam int HOLD = 20;

    logic       clk = 1'b0;
    logic [1:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;

    int errors      = 0;
    int checks      = 0;
    int model_count = 0;

    logic [7:0] seg_tab [16];

    typedef struct {
        logic [9:0] sw;
        logic [9:0] ledr;
        logic [7:0] h0;
        logic [7:0] h1;
        logic [7:0] h2;
        logic [7:0] h3;
    } vec_t;
    vec_t vecs [6];

    cmp_sequencer #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
        .MAX10_CLK1_50(clk),
        .KEY(key),
        .SW(sw),
        .LEDR(ledr),
        .HEX0(hex0),
        .HEX1(hex1),
        .HEX2(hex2),
        .HEX3(hex3),
        .HEX4(hex4),
        .HEX5(hex5)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] model_ledr(input logic [9:0] s);
        int   a  = int'(s[3:0]);
        int   b  = int'(s[7:4]);
        int   m  = int'(s[9:8]);
        int   ca = a;
        int   cb = b;
        logic lt, eq, gt;
        if (m == 1) begin
            if (a > 7) ca = a - 16;
            if (b > 7) cb = b - 16;
        end
        eq = (a == b);
        lt = (m != 2) && (ca < cb);
        gt = (m != 2) && (ca > cb);
        return {1'b1, 6'b000000, gt, eq, lt};
    endfunction

    function automatic logic [7:0] model_hex3(input logic [9:0] s);
        int a = int'(s[3:0]);
        int b = int'(s[7:4]);
        if (s[9:8] != 2'b11) return 8'hFF;
        return seg_tab[(a > b) ? a : b];
    endfunction

    // Press and hold the key until the first SHOW cycle, then release it.
    task automatic start_eval(input logic [9:0] s);
        int n = 0;
        sw     = s;
        key[1] = 1'b0;
        while (!ledr[9] && n < 40) begin
            tick();
            n++;
        end
        if (!ledr[9]) begin
            chk("busy_timeout", 0, 1);
        end else begin
            chk("eval_hex2_blank", hex2, 8'hFF);
            chk("eval_flags_off", ledr[2:0], 3'b000);
            tick();
            chk("eval_one_cycle", hex2 != 8'hFF, 1);
            model_count = (model_count + 1) % 100;
        end
        key[1] = 1'b1;
    endtask

    task automatic check_show(input logic [9:0] s);
        sw = ~s;
        #1;
        chk("show_ledr", ledr, model_ledr(s));
        chk("show_hex0", hex0, seg_tab[s[3:0]]);
        chk("show_hex1", hex1, seg_tab[s[7:4]]);
        chk("show_hex2", hex2, seg_tab[{2'b00, s[9:8]}]);
        chk("show_hex3", hex3, model_hex3(s));
        chk("show_hex4", hex4, seg_tab[model_count % 10]);
        chk("show_hex5", hex5, seg_tab[model_count / 10]);
    endtask

    task automatic wait_idle(input int exp_len);
        int n = 0;
        while (ledr[9] && n < 60) begin
            tick();
            n++;
        end
        if (ledr[9]) chk("idle_timeout", 0, 1);
        else if (exp_len >= 0) chk("show_hold_len", n, exp_len);
        repeat (DB + 4) tick();
    endtask

    initial begin
        int rises;
        int n;
        logic prev;
        logic [9:0] s;

        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        vecs[0] = '{10'b00_0101_1100, 10'b10_0000_0100, 8'hC6, 8'h92, 8'hC0, 8'hFF};
        vecs[1] = '{10'b01_1100_0101, 10'b10_0000_0100, 8'h92, 8'hC6, 8'hF9, 8'hFF};
        vecs[2] = '{10'b00_1100_0101, 10'b10_0000_0001, 8'h92, 8'hC6, 8'hC0, 8'hFF};
        vecs[3] = '{10'b10_0110_0110, 10'b10_0000_0010, 8'h82, 8'h82, 8'hA4, 8'hFF};
        vecs[4] = '{10'b11_1001_0011, 10'b10_0000_0001, 8'hB0, 8'h90, 8'hB0, 8'h90};
        vecs[5] = '{10'b10_1001_0011, 10'b10_0000_0000, 8'hB0, 8'h90, 8'hA4, 8'hFF};

        // Reset state with live switch display
        key = 2'b10;
        sw  = 10'h2A5;
        repeat (3) tick();
        chk("rst_ledr", ledr, 10'h000);
        chk("rst_hex0", hex0, seg_tab[5]);
        chk("rst_hex1", hex1, seg_tab[10]);
        chk("rst_hex2", hex2, 8'hFF);
        chk("rst_hex3", hex3, 8'hFF);
        chk("rst_hex4", hex4, 8'hC0);
        chk("rst_hex5", hex5, 8'hC0);
        key[0] = 1'b1;
        repeat (3) tick();
        sw = 10'h0E7;
        #1;
        chk("idle_live_hex0", hex0, seg_tab[7]);
        chk("idle_live_hex1", hex1, seg_tab[14]);
        chk("idle_ledr", ledr, 10'h000);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            start_eval(vecs[i].sw);
            sw = ~vecs[i].sw;
            #1;
            chk("vec_ledr", ledr, vecs[i].ledr);
            chk("vec_hex0", hex0, vecs[i].h0);
            chk("vec_hex1", hex1, vecs[i].h1);
            chk("vec_hex2", hex2, vecs[i].h2);
            chk("vec_hex3", hex3, vecs[i].h3);
            chk("vec_hex4", hex4, seg_tab[model_count % 10]);
            wait_idle(HOLD);
        end

        // Bounce: 2-cycle pulses never reach the debounce length
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            key[1] = ~key[1];
            repeat (2) begin
                tick();
                if (ledr[9]) rises++;
            end
        end
        key[1] = 1'b1;
        repeat (DB + 4) begin
            tick();
            if (ledr[9]) rises++;
        end
        chk("bounce_no_step", rises, 0);
        chk("bounce_hex4", hex4, seg_tab[model_count % 10]);

        // Long hold gives exactly one evaluation
        rises  = 0;
        prev   = ledr[9];
        key[1] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ledr[9] && !prev) rises++;
            prev = ledr[9];
        end
        key[1] = 1'b1;
        repeat (DB + 4) tick();
        model_count = (model_count + 1) % 100;
        chk("hold_one_eval", rises, 1);
        chk("hold_hex4", hex4, seg_tab[model_count % 10]);
        chk("hold_idle", ledr[9], 1'b0);

        // A step in SHOW returns to IDLE early and is not reused
        s = 10'b00_0010_0111;
        start_eval(s);
        check_show(s);
        repeat (DB + 4) tick();
        key[1] = 1'b0;
        n = 0;
        while (ledr[9] && n < 40) begin
            tick();
            n++;
        end
        chk("step_exit_early", (DB + 4 + n) < HOLD, 1);
        rises = 0;
        repeat (30) begin
            tick();
            if (ledr[9]) rises++;
        end
        chk("step_consumed", rises, 0);
        key[1] = 1'b1;
        repeat (DB + 4) tick();

        // Reset mid-SHOW aborts immediately
        start_eval(10'b11_0001_1000);
        repeat (3) tick();
        key[0] = 1'b0;
        #1;
        model_count = 0;
        chk("rst_show_ledr", ledr, 10'h000);
        chk("rst_show_hex2", hex2, 8'hFF);
        chk("rst_show_hex4", hex4, 8'hC0);
        chk("rst_show_hex5", hex5, 8'hC0);

        // Key held through reset release counts as one press
        key[1] = 1'b0;
        repeat (3) tick();
        key[0] = 1'b1;
        n = 0;
        while (!ledr[9] && n < 40) begin
            tick();
            n++;
        end
        chk("held_after_reset", ledr[9], 1'b1);
        model_count = 1;
        wait_idle(-1);
        key[1] = 1'b1;
        repeat (DB + 4) tick();
        chk("held_after_reset_cnt", hex4, seg_tab[1]);

        // Randomized evaluations through a full counter wrap
        key[0] = 1'b0;
        tick();
        key[0] = 1'b1;
        model_count = 0;
        repeat (2) tick();
        for (int i = 0; i < 100; i++) begin
            s = 10'($urandom_range(0, 1023));
            if (i % 7 == 0) s[7:4] = s[3:0];
            start_eval(s);
            check_show(s);
            wait_idle(HOLD);
        end
        chk("wrap_hex4", hex4, 8'hC0);
        chk("wrap_hex5", hex5, 8'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
